// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and width helper shared by the serial transmit and capture sides.
package serial_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loadable shift register that also reports the bit it will present after the next edge.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_next_bit
);
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next     = i_load ? i_data : i_shift ? (MSB_FIRST ? r_shreg << 1 : r_shreg >> 1) : r_shreg;
        o_next_bit = MSB_FIRST ? w_next[WIDTH-1] : w_next[0];
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_shreg <= '0;
        else          r_shreg <= w_next;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a word over valid/ready and sends it one bit per clock,
// optionally followed by an even-parity bit, with gapless back-to-back frames.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1,
    parameter bit PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_par, r_ser_out, r_ser_valid, r_frame_start;
    logic          w_last_data, w_accept, w_next_bit;

    always_comb begin
        w_last_data = (r_state == ST_SHIFT) && (r_cnt == LAST);
        load_ready  = (r_state == ST_IDLE) || (PARITY_EN ? (r_state == ST_PARITY) : w_last_data);
        w_accept    = load_valid && load_ready;
        w_cnt_nxt   = (r_state == ST_SHIFT && !w_last_data) ? r_cnt + CW'(1) : '0;
        w_state_nxt = w_accept ? ST_SHIFT
                    : (w_last_data && PARITY_EN) ? ST_PARITY
                    : (w_last_data || r_state == ST_PARITY) ? ST_IDLE
                    : r_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_par         <= 1'b0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            if (w_accept) r_par <= ^load_data;
            // the output flop captures the bit that belongs to the next cycle's state
            r_ser_out     <= (w_state_nxt == ST_SHIFT) ? w_next_bit : (w_state_nxt == ST_PARITY) && r_par;
            r_ser_valid   <= w_state_nxt != ST_IDLE;
            r_frame_start <= w_accept;
        end
    end

    piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_accept),
        .i_shift    (r_state == ST_SHIFT),
        .i_data     (load_data),
        .o_next_bit (w_next_bit)
    );

    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_ser_valid;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of four serializer configurations sharing one clock and reset.
module tb_piso_serializer;
    logic clk, reset_n;
    logic a_valid, a_ready, a_out, a_sv, a_fs, a_busy;
    logic b_valid, b_ready, b_out, b_sv, b_fs, b_busy;
    logic c_valid, c_ready, c_out, c_sv, c_fs, c_busy;
    logic d_valid, d_ready, d_out, d_sv, d_fs, d_busy;
    logic [7:0] a_data, b_data, c_data;
    logic [0:0] d_data;
    int n_checks, n_fail;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_a (
        .clk(clk), .reset_n(reset_n), .load_valid(a_valid), .load_data(a_data), .load_ready(a_ready),
        .ser_out(a_out), .ser_valid(a_sv), .frame_start(a_fs), .busy(a_busy));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_b (
        .clk(clk), .reset_n(reset_n), .load_valid(b_valid), .load_data(b_data), .load_ready(b_ready),
        .ser_out(b_out), .ser_valid(b_sv), .frame_start(b_fs), .busy(b_busy));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_c (
        .clk(clk), .reset_n(reset_n), .load_valid(c_valid), .load_data(c_data), .load_ready(c_ready),
        .ser_out(c_out), .ser_valid(c_sv), .frame_start(c_fs), .busy(c_busy));
    piso_serializer #(.WIDTH(1), .MSB_FIRST(1), .PARITY_EN(0)) u_d (
        .clk(clk), .reset_n(reset_n), .load_valid(d_valid), .load_data(d_data), .load_ready(d_ready),
        .ser_out(d_out), .ser_valid(d_sv), .frame_start(d_fs), .busy(d_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a_out, a_sv, a_fs, a_busy, a_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_a out/valid/fs/busy/ready got %b exp 00001", {a_out, a_sv, a_fs, a_busy, a_ready});
        end
        n_checks++;
        if ({b_sv, b_ready, c_sv, c_ready, d_sv, d_ready} !== 6'b010101) begin
            n_fail++; $display("FAIL reset_bcd valid/ready got %b exp 010101", {b_sv, b_ready, c_sv, c_ready, d_sv, d_ready});
        end
        reset_n = 1'b1;
    endtask

    // accept one word on instance a; first bit is visible at the following negedge
    task automatic send_a(input logic [7:0] d);
        @(posedge clk); #1 a_valid = 1'b1; a_data = d;
        @(posedge clk); #1 a_valid = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [7:0] d;
        d = 8'hA5;
        send_a(d);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_out, a_sv, a_fs, a_ready} !== {d[7-i], 1'b1, i == 0, i == 7}) begin
                n_fail++; $display("FAIL msb_first bit%0d out/valid/fs/ready got %b exp %b", i, {a_out, a_sv, a_fs, a_ready}, {d[7-i], 1'b1, i == 0, i == 7});
            end
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({a_out, a_sv, a_fs, a_ready} !== 4'b0001) begin
                n_fail++; $display("FAIL msb_first_idle out/valid/fs/ready got %b exp 0001", {a_out, a_sv, a_fs, a_ready});
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic [8:0] exp_bits;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 8'h07 : 8'h03;
            exp_bits = {d, (k == 0) ? 1'b1 : 1'b0};
            @(posedge clk); #1 b_valid = 1'b1; b_data = d;
            @(posedge clk); #1 b_valid = 1'b0; b_data = 8'hFF;
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                n_checks++;
                if ({b_out, b_sv, b_fs, b_ready} !== {exp_bits[8-i], 1'b1, i == 0, i == 8}) begin
                    n_fail++; $display("FAIL parity d=%h bit%0d out/valid/fs/ready got %b exp %b", d, i, {b_out, b_sv, b_fs, b_ready}, {exp_bits[8-i], 1'b1, i == 0, i == 8});
                end
            end
            @(negedge clk);
            n_checks++;
            if ({b_out, b_sv, b_ready} !== 3'b001) begin
                n_fail++; $display("FAIL parity_idle d=%h out/valid/ready got %b exp 001", d, {b_out, b_sv, b_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1 a_valid = 1'b1; a_data = 8'hFF;
        @(posedge clk); #1 a_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_out, a_sv, a_fs, a_ready} !== {i < 8, 1'b1, i == 0 || i == 8, i == 7 || i == 15}) begin
                n_fail++; $display("FAIL back_to_back cyc%0d out/valid/fs/ready got %b exp %b", i, {a_out, a_sv, a_fs, a_ready}, {i < 8, 1'b1, i == 0 || i == 8, i == 7 || i == 15});
            end
            if (i == 8) a_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({a_sv, a_ready} !== 2'b01) begin
            n_fail++; $display("FAIL back_to_back_idle valid/ready got %b exp 01", {a_sv, a_ready});
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] d;
        d = 8'h01;
        @(posedge clk); #1 c_valid = 1'b1; c_data = d;
        @(posedge clk); #1 c_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({c_out, c_sv, c_fs, c_ready} !== {d[i], 1'b1, i == 0, i == 7}) begin
                n_fail++; $display("FAIL lsb_first bit%0d out/valid/fs/ready got %b exp %b", i, {c_out, c_sv, c_fs, c_ready}, {d[i], 1'b1, i == 0, i == 7});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        send_a(8'hF0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_out, a_sv} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset out/valid got %b exp 11", {a_out, a_sv});
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a_out, a_sv, a_busy} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset out/valid/busy got %b exp 000", {a_out, a_sv, a_busy});
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_ready, a_sv} !== 2'b10) begin
            n_fail++; $display("FAIL after_reset ready/valid got %b exp 10", {a_ready, a_sv});
        end
        d = 8'h3C;
        send_a(d);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_out, a_sv, a_fs} !== {d[7-i], 1'b1, i == 0}) begin
                n_fail++; $display("FAIL post_reset bit%0d out/valid/fs got %b exp %b", i, {a_out, a_sv, a_fs}, {d[7-i], 1'b1, i == 0});
            end
        end
        @(negedge clk);
        n_checks++;
        if (a_sv !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle valid got %b exp 0", a_sv);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] d;
        d = 8'h5A;
        send_a(d);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_out, a_fs, a_ready, a_busy} !== {d[7-i], i == 0, i == 7, 1'b1}) begin
                n_fail++; $display("FAIL busy_ignore bit%0d out/fs/ready/busy got %b exp %b", i, {a_out, a_fs, a_ready, a_busy}, {d[7-i], i == 0, i == 7, 1'b1});
            end
            if (i == 2) begin a_valid = 1'b1; a_data = 8'hFF; end
            if (i == 4) a_data = 8'h00;
            if (i == 6) a_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({a_sv, a_ready} !== 2'b01) begin
            n_fail++; $display("FAIL busy_ignore_idle valid/ready got %b exp 01", {a_sv, a_ready});
        end
    endtask

    task automatic test_width1();
        @(posedge clk); #1 d_valid = 1'b1; d_data = 1'b1;
        @(posedge clk); #1 d_valid = 1'b0; d_data = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({d_out, d_sv, d_fs, d_ready} !== 4'b1111) begin
            n_fail++; $display("FAIL width1_bit out/valid/fs/ready got %b exp 1111", {d_out, d_sv, d_fs, d_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({d_out, d_sv, d_fs, d_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL width1_idle out/valid/fs/ready got %b exp 0001", {d_out, d_sv, d_fs, d_ready});
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset_n = 1'b0;
        {a_valid, b_valid, c_valid, d_valid} = '0;
        a_data = '0; b_data = '0; c_data = '0; d_data = '0;
        test_reset();
        test_msb_first();
        test_parity();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_frame();
        test_busy_ignore();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
